// File: rtl/regmask_encoder_16_4.sv
// regmask_encoder_16_4: serialises a 16-bit register mask into the 4-bit IDs of its set bits, lowest first
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   mask_valid_i      mask offered
//   mask_ready_o      mask accepted this cycle if offered (high only while idle)
//   mask_i[15:0]      register mask, bit i set = emit ID i
//   id_valid_o        id_o carries a pending register ID
//   id_ready_i        consumer takes id_o this cycle
//   id_o[3:0]         lowest pending register ID
//   id_last_o         id_o is the final ID of the current mask
//   remaining_o[4:0]  number of IDs still pending
//   done_o            one-cycle pulse after a mask is fully emitted or was empty
module regmask_encoder_16_4 (
    input  logic        clk,
    input  logic        rst,
    input  logic        mask_valid_i,
    output logic        mask_ready_o,
    input  logic [15:0] mask_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [3:0]  id_o,
    output logic        id_last_o,
    output logic [4:0]  remaining_o,
    output logic        done_o
);
    typedef enum logic {IDLE, EMIT} state_t;
    state_t      state_q, state_d;
    logic [15:0] pending_q, pending_d;
    logic        done_q, done_d;
    logic [3:0]  low;
    logic [4:0]  cnt;
    always_comb begin
        low = '0;
        for (int i = 15; i >= 0; i--) low = pending_q[i] ? 4'(i) : low;
        cnt = '0;
        for (int i = 0; i < 16; i++) cnt = cnt + 5'(pending_q[i]);
    end
    assign mask_ready_o = state_q == IDLE;
    assign id_valid_o   = state_q == EMIT;
    assign id_o         = id_valid_o ? low : 4'd0;
    assign id_last_o    = id_valid_o && cnt == 5'd1;
    assign remaining_o  = cnt;
    assign done_o       = done_q;
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        if (mask_ready_o && mask_valid_i) begin
            state_d   = mask_i != '0 ? EMIT : IDLE;
            pending_d = mask_i;
            done_d    = mask_i == '0;
        end else if (id_valid_o && id_ready_i) begin
            // clearing the emitted bit makes the next lowest set bit win the encoder
            pending_d = pending_q & ~(16'h1 << low);
            state_d   = id_last_o ? IDLE : EMIT;
            done_d    = id_last_o;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_regmask_encoder_16_4.sv
// tb_regmask_encoder_16_4: scenario and randomized checks of regmask_encoder_16_4 against a set-bit list model
module tb_regmask_encoder_16_4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mask_valid = 1'b0;
    logic        mask_ready;
    logic [15:0] mask = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [3:0]  id;
    logic        id_last;
    logic [4:0]  remaining;
    logic        done;
    int          n_checks = 0;
    int          n_fail = 0;

    regmask_encoder_16_4 dut (
        .clk(clk), .rst(rst),
        .mask_valid_i(mask_valid), .mask_ready_o(mask_ready), .mask_i(mask),
        .id_valid_o(id_valid), .id_ready_i(id_ready), .id_o(id),
        .id_last_o(id_last), .remaining_o(remaining), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_ids(input logic [15:0] m, output int q[$]);
        q = {};
        for (int i = 0; i < 16; i++) if (m[i]) q.push_back(i);
    endtask

    task automatic test_reset;
        rst = 1'b1; mask_valid = 1'b1; mask = 16'h00FF; id_ready = 1'b1;
        repeat (2) begin
            tick;
            n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
            n_checks++; if (mask_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mask_ready got=%b exp=1", mask_ready); end
            n_checks++; if (remaining !== 5'd0) begin n_fail++; $display("FAIL reset_remaining got=%0d exp=0", remaining); end
        end
        rst = 1'b0;
        tick;
        mask_valid = 1'b0;
        n_checks++; if (id_valid !== 1'b1 || remaining !== 5'd8 || id !== 4'd0) begin
            n_fail++; $display("FAIL reset_first_accept got v=%b rem=%0d id=%0d exp v=1 rem=8 id=0", id_valid, remaining, id);
        end
        repeat (8) tick;
        n_checks++; if (done !== 1'b1 || mask_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_drain_done got done=%b rdy=%b exp 1 1", done, mask_ready);
        end
        tick;
    endtask

    task automatic test_basic;
        int q[$];
        model_ids(16'h8421, q);
        mask_valid = 1'b1; mask = 16'h8421; id_ready = 1'b1;
        tick;
        mask_valid = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            n_checks++; if (id_valid !== 1'b1 || id !== 4'(q[k])) begin
                n_fail++; $display("FAIL basic_id k=%0d got v=%b id=%0d exp v=1 id=%0d", k, id_valid, id, q[k]);
            end
            n_checks++; if (remaining !== 5'(q.size() - k)) begin
                n_fail++; $display("FAIL basic_remaining k=%0d got=%0d exp=%0d", k, remaining, q.size() - k);
            end
            n_checks++; if (id_last !== (k == q.size() - 1) || mask_ready !== 1'b0) begin
                n_fail++; $display("FAIL basic_last k=%0d got last=%b rdy=%b exp last=%b rdy=0", k, id_last, mask_ready, k == q.size() - 1);
            end
            tick;
        end
        n_checks++; if (done !== 1'b1 || mask_ready !== 1'b1 || id_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_done got done=%b rdy=%b v=%b exp 1 1 0", done, mask_ready, id_valid);
        end
        tick;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_empty;
        mask_valid = 1'b1; mask = 16'h0000; id_ready = 1'b1;
        tick;
        mask_valid = 1'b0;
        n_checks++; if (done !== 1'b1 || id_valid !== 1'b0 || mask_ready !== 1'b1) begin
            n_fail++; $display("FAIL empty_done got done=%b v=%b rdy=%b exp 1 0 1", done, id_valid, mask_ready);
        end
        repeat (3) begin
            tick;
            n_checks++; if (done !== 1'b0 || id_valid !== 1'b0 || mask_ready !== 1'b1) begin
                n_fail++; $display("FAIL empty_after got done=%b v=%b rdy=%b exp 0 0 1", done, id_valid, mask_ready);
            end
        end
    endtask

    task automatic test_stall;
        int q[$];
        int hs = 0;
        int c = 0;
        int dones = 0;
        model_ids(16'hFFFF, q);
        mask_valid = 1'b1; mask = 16'hFFFF; id_ready = 1'b0;
        tick;
        mask_valid = 1'b0;
        while (hs < 16 && c < 64) begin
            n_checks++; if (id_valid !== 1'b1 || id !== 4'(q[hs]) || remaining !== 5'(16 - hs) || id_last !== (hs == 15)) begin
                n_fail++; $display("FAIL stall_id hs=%0d got v=%b id=%0d rem=%0d last=%b exp v=1 id=%0d rem=%0d last=%b",
                                   hs, id_valid, id, remaining, id_last, q[hs], 16 - hs, hs == 15);
            end
            if (done) dones++;
            id_ready = (c % 2) == 0;
            if (id_ready) hs++;
            tick;
            c++;
        end
        id_ready = 1'b0;
        n_checks++; if (hs !== 16) begin n_fail++; $display("FAIL stall_handshakes got=%0d exp=16", hs); end
        n_checks++; if (done !== 1'b1 || dones !== 0) begin
            n_fail++; $display("FAIL stall_done got done=%b early=%0d exp 1 0", done, dones);
        end
        tick;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL stall_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_reset_mid;
        mask_valid = 1'b1; mask = 16'h00F0; id_ready = 1'b1;
        tick;
        mask_valid = 1'b0;
        n_checks++; if (id !== 4'd4) begin n_fail++; $display("FAIL midrst_first got=%0d exp=4", id); end
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++; if (id_valid !== 1'b0 || remaining !== 5'd0 || done !== 1'b0 || mask_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_state got v=%b rem=%0d done=%b rdy=%b exp 0 0 0 1", id_valid, remaining, done, mask_ready);
        end
        tick;
        n_checks++; if (done !== 1'b0 || id_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_nodone got done=%b v=%b exp 0 0", done, id_valid);
        end
        mask_valid = 1'b1; mask = 16'h0003;
        tick;
        mask_valid = 1'b0;
        n_checks++; if (id !== 4'd0 || id_last !== 1'b0) begin n_fail++; $display("FAIL midrst_id0 got id=%0d last=%b exp 0 0", id, id_last); end
        tick;
        n_checks++; if (id !== 4'd1 || id_last !== 1'b1) begin n_fail++; $display("FAIL midrst_id1 got id=%0d last=%b exp 1 1", id, id_last); end
        tick;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL midrst_done got=%b exp=1", done); end
        tick;
    endtask

    task automatic test_back_to_back;
        mask_valid = 1'b1; mask = 16'h0101; id_ready = 1'b1;
        tick;
        mask = 16'h0002;
        n_checks++; if (id !== 4'd0 || mask_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_id0 got id=%0d rdy=%b exp 0 0", id, mask_ready); end
        tick;
        n_checks++; if (id !== 4'd8 || id_last !== 1'b1) begin n_fail++; $display("FAIL b2b_id8 got id=%0d last=%b exp 8 1", id, id_last); end
        tick;
        n_checks++; if (done !== 1'b1 || mask_ready !== 1'b1 || id_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_bubble got done=%b rdy=%b v=%b exp 1 1 0", done, mask_ready, id_valid);
        end
        tick;
        mask_valid = 1'b0;
        n_checks++; if (id_valid !== 1'b1 || id !== 4'd1 || remaining !== 5'd1 || id_last !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second got v=%b id=%0d rem=%0d last=%b done=%b exp 1 1 1 1 0", id_valid, id, remaining, id_last, done);
        end
        tick;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done got=%b exp=1", done); end
        tick;
    endtask

    task automatic test_random;
        int q[$];
        logic [15:0] cur = '0;
        logic [15:0] acc = '0;
        bit exp_done = 1'b0;
        bit nd;
        int r;
        for (int it = 0; it < 600; it++) begin
            n_checks++; if (id_valid !== (q.size() != 0)) begin
                n_fail++; $display("FAIL rand_valid it=%0d got=%b exp=%b", it, id_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                n_checks++; if (id !== 4'(q[0]) || remaining !== 5'(q.size()) || id_last !== (q.size() == 1) || mask_ready !== 1'b0) begin
                    n_fail++; $display("FAIL rand_id it=%0d got id=%0d rem=%0d last=%b rdy=%b exp id=%0d rem=%0d last=%b rdy=0",
                                       it, id, remaining, id_last, mask_ready, q[0], q.size(), q.size() == 1);
                end
            end else begin
                n_checks++; if (mask_ready !== 1'b1 || remaining !== 5'd0 || id !== 4'd0 || id_last !== 1'b0) begin
                    n_fail++; $display("FAIL rand_idle it=%0d got rdy=%b rem=%0d id=%0d last=%b exp 1 0 0 0", it, mask_ready, remaining, id, id_last);
                end
            end
            n_checks++; if (done !== exp_done) begin n_fail++; $display("FAIL rand_done it=%0d got=%b exp=%b", it, done, exp_done); end
            if (exp_done) begin
                n_checks++; if (acc !== cur) begin n_fail++; $display("FAIL rand_cover it=%0d got=%h exp=%h", it, acc, cur); end
            end
            r = $urandom_range(0, 7);
            mask = r == 0 ? 16'h0000 : r == 1 ? 16'hFFFF : 16'($urandom) & 16'($urandom);
            mask_valid = $urandom_range(0, 2) == 0;
            id_ready = $urandom_range(0, 1) == 1;
            nd = 1'b0;
            if (q.size() == 0 && mask_valid) begin
                cur = mask;
                acc = '0;
                model_ids(mask, q);
                nd = q.size() == 0;
            end else if (q.size() != 0 && id_ready) begin
                acc = acc | (16'h1 << id);
                void'(q.pop_front());
                nd = q.size() == 0;
            end
            tick;
            exp_done = nd;
        end
        mask_valid = 1'b0;
        id_ready = 1'b1;
        repeat (20) tick;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_empty;
        test_stall;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
